// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller.
package seq_mult_ctrl_pkg;

    // Controller states; the encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bits needed to hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_mult_ctrl_mq_4bit.sv
// Existing 4-bit partial-product generator: multiplicand gated by one multiplier bit.
module mq_4bit
    import seq_mult_ctrl_pkg::*;
(
    input  logic [3:0] mcand_i,
    input  logic       mbit_i,
    output logic [3:0] pp_o
);

    // Broadcast the selected multiplier bit across every multiplicand bit.
    always_comb begin
        pp_o = mcand_i & {4{mbit_i}};
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier: one partial product per cycle over WIDTH cycles.
module seq_mult_ctrl
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = clog2(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t          state_q,   state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic [PW-1:0]    product_q, product_d;

    logic             multBit;
    logic [WIDTH-1:0] partialProd;
    logic [PW-1:0]    shiftedProd;
    logic [PW-1:0]    accSum;

    assign multBit = b_q[cnt_q];

    // The 4-bit build reuses the existing generator; other widths use an equivalent AND array.
    generate
        if (WIDTH == 4) begin : gMq4
            mq_4bit uMq4 (
                .mcand_i (a_q),
                .mbit_i  (multBit),
                .pp_o    (partialProd)
            );
        end else begin : gMqGeneric
            for (genvar i = 0; i < WIDTH; i++) begin : gBit
                assign partialProd[i] = a_q[i] & multBit;
            end
        end
    endgenerate

    // Align the current partial product to its bit weight and add it to the running sum.
    always_comb begin
        shiftedProd = {{WIDTH{1'b0}}, partialProd} << cnt_q;
        accSum      = acc_q + shiftedProd;
    end

    // State, operand, counter, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    // Next-state logic: accept in IDLE/DONE, accumulate one bit per cycle in RUN, abort only in RUN.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    product_d = '0;
                    state_d   = IDLE;
                end else begin
                    acc_d = accSum;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d     = '0;
                        product_d = accSum;
                        state_d   = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule
